// File: rtl/epass_fee_checker_if.sv
// rtl/epass_fee_checker_if.sv - controller/card-reader side signals of the E-pass fee checker
interface epass_fee_checker_if #(
    parameter int TIME_W = 16,
    parameter int BAL_W  = 16,
    parameter int FEE_W  = 8
);
    logic              init;
    logic              count;
    logic              cal;
    logic              card_valid;
    logic              card_id_ok;
    logic [BAL_W-1:0]  card_balance;
    logic [1:0]        valid_Epass;
    logic              done;
    logic              charge;
    logic [FEE_W-1:0]  fee;
    logic              overspeed;
    logic [TIME_W-1:0] transit_time;

    modport slave (
        input  init, count, cal, card_valid, card_id_ok, card_balance,
        output valid_Epass, done, charge, fee, overspeed, transit_time
    );

    modport master (
        output init, count, cal, card_valid, card_id_ok, card_balance,
        input  valid_Epass, done, charge, fee, overspeed, transit_time
    );
endinterface

// File: rtl/epass_fee_checker.sv
// rtl/epass_fee_checker.sv - transit timing, pricing and E-pass balance verdict for one vehicle
module epass_fee_checker #(
    parameter int TIME_W       = 16,
    parameter int BAL_W        = 16,
    parameter int FEE_W        = 8,
    parameter int FEE_BASE     = 10,
    parameter int FEE_FINE     = 50,
    parameter int T_FAST       = 1000,
    parameter int CARD_TIMEOUT = 5000
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    epass_fee_checker_if.slave   bus
);
    localparam int TMO_W = $clog2(CARD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        TIMING,
        FEE,
        WAIT_CARD,
        VERDICT
    } state_t;

    state_t            state_q, state_d;
    logic [TIME_W-1:0] transit_q, transit_d;
    logic [FEE_W-1:0]  fee_q, fee_d;
    logic              ovs_q, ovs_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [1:0]        valid_q, valid_d;
    logic              done_q, done_d;
    logic              charge_q, charge_d;
    logic              accept;
    logic              fast;

    assign accept = bus.card_id_ok && (bus.card_balance >= BAL_W'(fee_q));
    assign fast   = 32'(transit_q) < 32'(T_FAST);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            transit_q <= '0;
            fee_q     <= '0;
            ovs_q     <= 1'b0;
            tmo_q     <= '0;
            valid_q   <= 2'b00;
            done_q    <= 1'b0;
            charge_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            transit_q <= transit_d;
            fee_q     <= fee_d;
            ovs_q     <= ovs_d;
            tmo_q     <= tmo_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            charge_q  <= charge_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        transit_d = transit_q;
        fee_d     = fee_q;
        ovs_d     = ovs_q;
        tmo_d     = tmo_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        charge_d  = 1'b0;
        if (bus.init) begin
            state_d   = IDLE;
            transit_d = '0;
            fee_d     = '0;
            ovs_d     = 1'b0;
            tmo_d     = '0;
            valid_d   = 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_d = 2'b00;
                    if (bus.count) begin
                        state_d   = TIMING;
                        transit_d = TIME_W'(1);
                    end else if (bus.cal) begin
                        state_d   = FEE;
                        transit_d = '0;
                    end
                end
                TIMING: begin
                    if (bus.cal) begin
                        state_d = FEE;
                    end else if (bus.count && (transit_q != {TIME_W{1'b1}})) begin
                        transit_d = transit_q + TIME_W'(1);
                    end
                end
                FEE: begin
                    ovs_d   = fast;
                    fee_d   = fast ? FEE_W'(FEE_FINE) : FEE_W'(FEE_BASE);
                    tmo_d   = '0;
                    state_d = WAIT_CARD;
                end
                WAIT_CARD: begin
                    valid_d = 2'b00;
                    // A card response on the timeout cycle still decides the verdict.
                    if (bus.card_valid) begin
                        valid_d  = accept ? 2'b10 : 2'b01;
                        charge_d = accept;
                        done_d   = 1'b1;
                        state_d  = VERDICT;
                    end else if (tmo_q == TMO_W'(CARD_TIMEOUT - 1)) begin
                        valid_d = 2'b01;
                        done_d  = 1'b1;
                        state_d = VERDICT;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                VERDICT: begin
                    state_d = VERDICT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.valid_Epass  = valid_q;
    assign bus.done         = done_q;
    assign bus.charge       = charge_q;
    assign bus.fee          = fee_q;
    assign bus.overspeed    = ovs_q;
    assign bus.transit_time = transit_q;
endmodule

// File: tb/tb_epass_fee_checker.sv
// tb/tb_epass_fee_checker.sv - directed bench for epass_fee_checker (default and TIME_W=4 instances)
module tb_epass_fee_checker;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    epass_fee_checker_if #(.TIME_W(16), .BAL_W(16), .FEE_W(8)) ifa ();
    epass_fee_checker_if #(.TIME_W(4),  .BAL_W(16), .FEE_W(8)) ifb ();

    epass_fee_checker dut_a (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (ifa.slave)
    );

    epass_fee_checker #(.TIME_W(4)) dut_b (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (ifb.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic price_a(input int n);
        ifa.count = 1'b1;
        repeat (n) tick();
        ifa.count = 1'b0;
        ifa.cal   = 1'b1;
        tick();
        ifa.cal   = 1'b0;
        tick();
    endtask

    task automatic card_a(input logic id_ok, input logic [15:0] bal);
        ifa.card_valid   = 1'b1;
        ifa.card_id_ok   = id_ok;
        ifa.card_balance = bal;
        tick();
        ifa.card_valid   = 1'b0;
    endtask

    task automatic init_a();
        ifa.init = 1'b1;
        tick();
        ifa.init = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ifa.init = 0; ifa.count = 0; ifa.cal = 0; ifa.card_valid = 0; ifa.card_id_ok = 0; ifa.card_balance = '0;
        ifb.init = 0; ifb.count = 0; ifb.cal = 0; ifb.card_valid = 0; ifb.card_id_ok = 0; ifb.card_balance = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", 32'(ifa.valid_Epass), 32'd0);
        check("rst_done", 32'(ifa.done), 32'd0);
        check("rst_charge", 32'(ifa.charge), 32'd0);
        check("rst_fee", 32'(ifa.fee), 32'd0);
        check("rst_ovs", 32'(ifa.overspeed), 32'd0);
        check("rst_transit", 32'(ifa.transit_time), 32'd0);

        // normal speed, exact balance accepted
        price_a(1200);
        check("t1_transit", 32'(ifa.transit_time), 32'd1200);
        check("t1_ovs", 32'(ifa.overspeed), 32'd0);
        check("t1_fee", 32'(ifa.fee), 32'd10);
        check("t1_pending", 32'(ifa.valid_Epass), 32'd0);
        card_a(1'b1, 16'd10);
        check("t1_valid", 32'(ifa.valid_Epass), 32'd2);
        check("t1_done", 32'(ifa.done), 32'd1);
        check("t1_charge", 32'(ifa.charge), 32'd1);
        ifa.count = 1'b1;
        ifa.cal   = 1'b1;
        tick();
        ifa.count = 1'b0;
        ifa.cal   = 1'b0;
        check("t1_done_once", 32'(ifa.done), 32'd0);
        check("t1_charge_once", 32'(ifa.charge), 32'd0);
        check("t1_hold", 32'(ifa.valid_Epass), 32'd2);
        check("t1_hold_transit", 32'(ifa.transit_time), 32'd1200);
        init_a();

        // 999 cycles is overspeed; balance one short of the fine
        price_a(999);
        check("t2_ovs", 32'(ifa.overspeed), 32'd1);
        check("t2_fee", 32'(ifa.fee), 32'd50);
        card_a(1'b1, 16'd49);
        check("t2_valid", 32'(ifa.valid_Epass), 32'd1);
        check("t2_done", 32'(ifa.done), 32'd1);
        check("t2_charge", 32'(ifa.charge), 32'd0);
        init_a();
        price_a(1000);
        check("t2b_ovs", 32'(ifa.overspeed), 32'd0);
        check("t2b_fee", 32'(ifa.fee), 32'd10);
        init_a();

        // card timeout
        price_a(1200);
        repeat (4999) tick();
        check("t3_pending", 32'(ifa.valid_Epass), 32'd0);
        tick();
        check("t3_valid", 32'(ifa.valid_Epass), 32'd1);
        check("t3_done", 32'(ifa.done), 32'd1);
        check("t3_charge", 32'(ifa.charge), 32'd0);
        init_a();
        price_a(1200);
        repeat (4999) tick();
        card_a(1'b1, 16'd100);
        check("t3b_valid", 32'(ifa.valid_Epass), 32'd2);
        check("t3b_charge", 32'(ifa.charge), 32'd1);
        init_a();

        // 4-bit timer saturates; unknown card rejected
        ifb.count = 1'b1;
        repeat (40) tick();
        ifb.count = 1'b0;
        check("t4_transit", 32'(ifb.transit_time), 32'd15);
        ifb.cal = 1'b1;
        tick();
        ifb.cal = 1'b0;
        tick();
        check("t4_ovs", 32'(ifb.overspeed), 32'd1);
        check("t4_fee", 32'(ifb.fee), 32'd50);
        ifb.card_valid   = 1'b1;
        ifb.card_id_ok   = 1'b0;
        ifb.card_balance = 16'd100;
        tick();
        ifb.card_valid   = 1'b0;
        check("t4_valid", 32'(ifb.valid_Epass), 32'd1);

        // init in WAIT_CARD and in VERDICT, reset in TIMING
        price_a(20);
        init_a();
        check("t5_wc_valid", 32'(ifa.valid_Epass), 32'd0);
        check("t5_wc_transit", 32'(ifa.transit_time), 32'd0);
        check("t5_wc_fee", 32'(ifa.fee), 32'd0);
        check("t5_wc_ovs", 32'(ifa.overspeed), 32'd0);
        price_a(20);
        card_a(1'b1, 16'd500);
        check("t5_vd_pre", 32'(ifa.valid_Epass), 32'd2);
        init_a();
        check("t5_vd_valid", 32'(ifa.valid_Epass), 32'd0);
        check("t5_vd_transit", 32'(ifa.transit_time), 32'd0);
        ifa.count = 1'b1;
        repeat (5) tick();
        check("t5_tm_pre", 32'(ifa.transit_time), 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ifa.count = 1'b0;
        check("t5_rst_transit", 32'(ifa.transit_time), 32'd0);
        check("t5_rst_valid", 32'(ifa.valid_Epass), 32'd0);
        card_a(1'b1, 16'd500);
        check("t5_stray_valid", 32'(ifa.valid_Epass), 32'd0);
        check("t5_stray_done", 32'(ifa.done), 32'd0);
        tick();
        check("t5_stray_idle", 32'(ifa.valid_Epass), 32'd0);

        // cal straight from IDLE prices as overspeed with zero transit
        ifa.cal = 1'b1;
        tick();
        ifa.cal = 1'b0;
        tick();
        check("t6_transit", 32'(ifa.transit_time), 32'd0);
        check("t6_ovs", 32'(ifa.overspeed), 32'd1);
        check("t6_fee", 32'(ifa.fee), 32'd50);
        card_a(1'b1, 16'd50);
        check("t6_valid", 32'(ifa.valid_Epass), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
